mem_controller_rr: RTL and testbench
====================================

MEM_CONTROLLER_RR -- requirements
Module: mem_controller_rr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16, meaning address width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, meaning number of requesters (>=1).
REQ-004 SHALL have parameter NUM_CHANNELS, default 2, meaning number of concurrent memory channels (>=1).
REQ-005 SHALL have parameter WRITE_ENABLE, default 1, meaning writes are accepted; 0 means read-only.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the watchdog limit (8-bit counter, 1..255).
REQ-007 SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, width 1, meaning asynchronous active-high reset.
REQ-009 SHALL have consumer_read_valid / consumer_write_valid, input, NUM_CONSUMERS, meaning per-consumer request held until the response.
REQ-010 SHALL have consumer_read_address / consumer_write_address, input, NUM_CONSUMERS x ADDRESS_WIDTH, meaning request addresses.
REQ-011 SHALL have consumer_write_data, input, NUM_CONSUMERS x DATA_WIDTH, meaning write payload.
REQ-012 SHALL have consumer_read_ready / consumer_write_ready, output, NUM_CONSUMERS, meaning response available.
REQ-013 SHALL have consumer_read_data, output, NUM_CONSUMERS x DATA_WIDTH, meaning read result, registered.
REQ-014 SHALL have consumer_error, output, NUM_CONSUMERS, meaning the response is a timeout abort.
REQ-015 SHALL have mem_read_valid / mem_write_valid, output, NUM_CHANNELS, with mem_read_address / mem_write_address (NUM_CHANNELS x ADDRESS_WIDTH) and mem_write_data (NUM_CHANNELS x DATA_WIDTH).
REQ-016 SHALL have mem_read_ready / mem_write_ready, input, NUM_CHANNELS, with mem_read_data (NUM_CHANNELS x DATA_WIDTH), meaning memory completion per channel.

Function
REQ-017 Each channel SHALL run the states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING; any other encoding SHALL return to IDLE next cycle.
REQ-018 Arbitration SHALL be round-robin: a single pointer rr_ptr names the highest-priority consumer; idle channels are filled in ascending channel index with eligible consumers in order rr_ptr, rr_ptr+1, ... modulo NUM_CONSUMERS.
REQ-019 A consumer is eligible when either valid is high and no channel is serving it; one consumer SHALL never be granted to two channels, including in the same cycle.
REQ-020 When read and write valid are both high for one consumer, the read SHALL be granted first.
REQ-021 If WRITE_ENABLE==0, write requests SHALL never be granted and consumer_write_ready SHALL stay 0.
REQ-022 On the cycle after any grant, rr_ptr SHALL equal (last granted consumer index + 1) mod NUM_CONSUMERS; with no grant it SHALL hold.
REQ-023 A grant on edge N SHALL drive mem_*_valid, address and data to the channel from edge N (1-cycle latency) and hold them until ready.
REQ-024 mem_*_ready sampled high in *_WAITING SHALL drop mem_*_valid and raise consumer_*_ready (with read data) on the next edge, then move to *_RELAYING.
REQ-025 In *_RELAYING, when the consumer's valid is low, the channel SHALL clear ready and error, free the consumer, and enter IDLE; it SHALL re-arbitrate no earlier than the following edge.
REQ-026 consumer_read_data SHALL hold its last value until the next read completion for that consumer.

Reset
REQ-027 Asserting reset SHALL immediately clear all outputs, rr_ptr, and the serving flags to 0, put every channel in IDLE, and zero the watchdogs, aborting any in-flight transaction without a response.
REQ-028 After reset deasserts, the first grant SHALL occur on the first clk edge that sees a valid request.

Configuration
REQ-029 Macro MEM_CTRL_TIMEOUT_EN: when defined, each *_WAITING channel SHALL count cycles; when TIMEOUT_CYCLES is reached without ready, it SHALL drop mem_*_valid and assert consumer_*_ready with consumer_error=1 (read data 0), then enter *_RELAYING.
REQ-030 Without MEM_CTRL_TIMEOUT_EN, there SHALL be no counter, consumer_error SHALL be tied 0, and channels SHALL wait indefinitely.

Verification
REQ-031 4 consumers x 2 channels, all read-valid at once, memory ready after 1 cycle -> grants {0,1}, then {2,3}, then {0,1}; rr_ptr sequence 0,2,0.
REQ-032 Consumer 2 reads 0x0040 and memory returns 0xDEADBEEF -> consumer_read_data[2]=0xDEADBEEF and ready 1 cycle after mem_read_ready; valid released -> channel IDLE next edge.
REQ-033 Consumer 1 has read and write valid together -> read served first; the write (addr 0x0010, data 0x12345678) is served only after the read completes.
REQ-034 WRITE_ENABLE=0 with a write request from consumer 0 -> mem_write_valid stays 0 for 50 cycles.
REQ-035 MEM_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=8 and memory never ready -> consumer_error and ready asserted 8 cycles after grant; without the macro, still waiting after 100 cycles.
REQ-036 Reset asserted mid READ_WAITING -> all outputs 0 before the next edge; no stale response after release.

Source files
------------

// File: rtl/mem_controller_rr_if.sv
// Consumer and memory-channel bundle for mem_controller_rr.
// slave = controller side, master = consumers plus memory model.
interface mem_controller_rr_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
);
    logic [NUM_CONSUMERS-1:0]                    consumer_read_valid;
    logic [NUM_CONSUMERS-1:0]                    consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                    consumer_read_ready;
    logic [NUM_CONSUMERS-1:0]                    consumer_write_ready;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                    consumer_error;

    logic [NUM_CHANNELS-1:0]                     mem_read_valid;
    logic [NUM_CHANNELS-1:0]                     mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_write_data;
    logic [NUM_CHANNELS-1:0]                     mem_read_ready;
    logic [NUM_CHANNELS-1:0]                     mem_write_ready;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_read_data;

    modport slave (
        input  consumer_read_valid, consumer_write_valid,
        input  consumer_read_address, consumer_write_address,
        input  consumer_write_data,
        output consumer_read_ready, consumer_write_ready,
        output consumer_read_data, consumer_error,
        output mem_read_valid, mem_write_valid,
        output mem_read_address, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_write_ready, mem_read_data
    );

    modport master (
        output consumer_read_valid, consumer_write_valid,
        output consumer_read_address, consumer_write_address,
        output consumer_write_data,
        input  consumer_read_ready, consumer_write_ready,
        input  consumer_read_data, consumer_error,
        input  mem_read_valid, mem_write_valid,
        input  mem_read_address, mem_write_address, mem_write_data,
        output mem_read_ready, mem_write_ready, mem_read_data
    );
endinterface

// File: rtl/mem_controller_rr.sv
// Round-robin multi-channel memory controller for N consumers.
// Define MEM_CTRL_TIMEOUT_EN to add a per-channel watchdog abort.
module mem_controller_rr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int NUM_CHANNELS   = 2,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic reset,
    mem_controller_rr_if.slave bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic WE = (WRITE_ENABLE != 0);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } state_t;

    state_t        st   [NUM_CHANNELS];
    logic [CW-1:0] cons [NUM_CHANNELS];
    logic [CW-1:0] rr_ptr;
    logic [NUM_CONSUMERS-1:0] serving;

    logic [NUM_CHANNELS-1:0]                    m_rvld;
    logic [NUM_CHANNELS-1:0]                    m_wvld;
    logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] m_raddr;
    logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] m_waddr;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    m_wdata;
    logic [NUM_CONSUMERS-1:0]                   c_rrdy;
    logic [NUM_CONSUMERS-1:0]                   c_wrdy;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]   c_rdata;

    logic [NUM_CONSUMERS-1:0] elig;
    logic [NUM_CONSUMERS-1:0] taken;
    logic [NUM_CHANNELS-1:0]  gnt;
    logic [NUM_CHANNELS-1:0]  gnt_wr;
    logic [CW-1:0]            gnt_idx [NUM_CHANNELS];
    logic                     any_gnt;
    logic [CW-1:0]            last_gnt;

    function automatic logic [CW-1:0] wrap(input logic [CW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
        return s[CW-1:0];
    endfunction

    assign elig = (bus.consumer_read_valid
                | (bus.consumer_write_valid & {NUM_CONSUMERS{WE}}))
                & ~serving;

    // Channels fill in ascending order; taken keeps a consumer on one channel.
    always_comb begin
        taken    = '0;
        gnt      = '0;
        gnt_wr   = '0;
        any_gnt  = 1'b0;
        last_gnt = rr_ptr;
        for (int c = 0; c < NUM_CHANNELS; c++) gnt_idx[c] = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (st[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    if (!gnt[c] && elig[wrap(rr_ptr, k)] && !taken[wrap(rr_ptr, k)]) begin
                        gnt[c]                  = 1'b1;
                        gnt_idx[c]              = wrap(rr_ptr, k);
                        gnt_wr[c]               = !bus.consumer_read_valid[wrap(rr_ptr, k)];
                        taken[wrap(rr_ptr, k)]  = 1'b1;
                        any_gnt                 = 1'b1;
                        last_gnt                = wrap(rr_ptr, k);
                    end
                end
            end
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]               wdog [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] c_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            serving <= '0;
            m_rvld  <= '0;
            m_wvld  <= '0;
            m_raddr <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
            c_rrdy  <= '0;
            c_wrdy  <= '0;
            c_rdata <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                st[c]   <= IDLE;
                cons[c] <= '0;
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            c_err <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) wdog[c] <= '0;
`endif
        end else begin
            if (any_gnt) rr_ptr <= wrap(last_gnt, 1);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (st[c])
                    IDLE: begin
                        if (gnt[c]) begin
                            cons[c]             <= gnt_idx[c];
                            serving[gnt_idx[c]] <= 1'b1;
`ifdef MEM_CTRL_TIMEOUT_EN
                            wdog[c] <= '0;
`endif
                            if (gnt_wr[c]) begin
                                st[c]      <= WRITE_WAITING;
                                m_wvld[c]  <= 1'b1;
                                m_waddr[c] <= bus.consumer_write_address[gnt_idx[c]];
                                m_wdata[c] <= bus.consumer_write_data[gnt_idx[c]];
                            end else begin
                                st[c]      <= READ_WAITING;
                                m_rvld[c]  <= 1'b1;
                                m_raddr[c] <= bus.consumer_read_address[gnt_idx[c]];
                            end
                        end
                    end
                    READ_WAITING: begin
                        if (bus.mem_read_ready[c]) begin
                            m_rvld[c]        <= 1'b0;
                            c_rrdy[cons[c]]  <= 1'b1;
                            c_rdata[cons[c]] <= bus.mem_read_data[c];
                            st[c]            <= READ_RELAYING;
                        end
`ifdef MEM_CTRL_TIMEOUT_EN
                        else if (wdog[c] == TMO_LAST) begin
                            m_rvld[c]        <= 1'b0;
                            c_rrdy[cons[c]]  <= 1'b1;
                            c_err[cons[c]]   <= 1'b1;
                            c_rdata[cons[c]] <= '0;
                            st[c]            <= READ_RELAYING;
                        end else begin
                            wdog[c] <= wdog[c] + 8'd1;
                        end
`endif
                    end
                    WRITE_WAITING: begin
                        if (bus.mem_write_ready[c]) begin
                            m_wvld[c]       <= 1'b0;
                            c_wrdy[cons[c]] <= 1'b1;
                            st[c]           <= WRITE_RELAYING;
                        end
`ifdef MEM_CTRL_TIMEOUT_EN
                        else if (wdog[c] == TMO_LAST) begin
                            m_wvld[c]       <= 1'b0;
                            c_wrdy[cons[c]] <= 1'b1;
                            c_err[cons[c]]  <= 1'b1;
                            st[c]           <= WRITE_RELAYING;
                        end else begin
                            wdog[c] <= wdog[c] + 8'd1;
                        end
`endif
                    end
                    READ_RELAYING: begin
                        if (!bus.consumer_read_valid[cons[c]]) begin
                            c_rrdy[cons[c]]  <= 1'b0;
                            serving[cons[c]] <= 1'b0;
                            st[c]            <= IDLE;
`ifdef MEM_CTRL_TIMEOUT_EN
                            c_err[cons[c]] <= 1'b0;
`endif
                        end
                    end
                    WRITE_RELAYING: begin
                        if (!bus.consumer_write_valid[cons[c]]) begin
                            c_wrdy[cons[c]]  <= 1'b0;
                            serving[cons[c]] <= 1'b0;
                            st[c]            <= IDLE;
`ifdef MEM_CTRL_TIMEOUT_EN
                            c_err[cons[c]] <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        st[c]     <= IDLE;
                        m_rvld[c] <= 1'b0;
                        m_wvld[c] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_read_valid       = m_rvld;
    assign bus.mem_write_valid      = m_wvld;
    assign bus.mem_read_address     = m_raddr;
    assign bus.mem_write_address    = m_waddr;
    assign bus.mem_write_data       = m_wdata;
    assign bus.consumer_read_ready  = c_rrdy;
    assign bus.consumer_write_ready = c_wrdy;
    assign bus.consumer_read_data   = c_rdata;
`ifdef MEM_CTRL_TIMEOUT_EN
    assign bus.consumer_error = c_err;
`else
    assign bus.consumer_error = '0;
`endif
endmodule

// File: tb/tb_mem_controller_rr.sv
// Directed bench for mem_controller_rr: arbitration order, handshakes,
// read-only build, watchdog (or its absence) and async reset abort.
module tb_mem_controller_rr;
    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NC  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_controller_rr_if #(DW, AW, NC, NCH) bus ();
    mem_controller_rr_if #(DW, AW, NC, NCH) bus_ro ();

    mem_controller_rr #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    mem_controller_rr #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(0), .TIMEOUT_CYCLES(8)
    ) u_ro (
        .clk(clk), .reset(reset), .bus(bus_ro.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.consumer_read_valid    = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        bus.mem_read_ready         = '0;
        bus.mem_write_ready        = '0;
        bus.mem_read_data          = '0;
        for (int i = 0; i < NC; i++) bus.consumer_read_address[i] = AW'(16'h0100 + i);
        bus_ro.consumer_read_valid    = '0;
        bus_ro.consumer_write_valid   = '0;
        bus_ro.consumer_read_address  = '0;
        bus_ro.consumer_write_address = '0;
        bus_ro.consumer_write_data    = '0;
        bus_ro.mem_read_ready         = '0;
        bus_ro.mem_write_ready        = '0;
        bus_ro.mem_read_data          = '0;

        #1 reset = 1'b1;
        #2;
        chk("rst_mrv", 64'(bus.mem_read_valid), 0);
        chk("rst_mwv", 64'(bus.mem_write_valid), 0);
        chk("rst_crr", 64'(bus.consumer_read_ready), 0);
        chk("rst_err", 64'(bus.consumer_error), 0);
        chk("rst_rd0", 64'(bus.consumer_read_data[0]), 0);
        chk("rst_ptr", 64'(u_dut.rr_ptr), 0);
        tick(2);
        reset = 1'b0;

        // all four consumers read at once on two channels
        bus.consumer_read_valid = 4'hF;
        tick();
        chk("rr1_vld", 64'(bus.mem_read_valid), 2'b11);
        chk("rr1_a0", 64'(bus.mem_read_address[0]), 16'h0100);
        chk("rr1_a1", 64'(bus.mem_read_address[1]), 16'h0101);
        chk("rr1_ptr", 64'(u_dut.rr_ptr), 2);
        bus.mem_read_ready = 2'b11;
        tick();
        chk("rr1_rdy", 64'(bus.consumer_read_ready), 4'b0011);
        chk("rr1_drop", 64'(bus.mem_read_valid), 0);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b1100;
        tick();
        chk("rr1_clr", 64'(bus.consumer_read_ready), 0);
        chk("rr1_hold", 64'(u_dut.rr_ptr), 2);
        bus.consumer_read_valid = 4'hF;
        tick();
        chk("rr2_a0", 64'(bus.mem_read_address[0]), 16'h0102);
        chk("rr2_a1", 64'(bus.mem_read_address[1]), 16'h0103);
        chk("rr2_ptr", 64'(u_dut.rr_ptr), 0);
        bus.mem_read_ready = 2'b11;
        tick();
        chk("rr2_rdy", 64'(bus.consumer_read_ready), 4'b1100);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b0011;
        tick(2);
        chk("rr3_a0", 64'(bus.mem_read_address[0]), 16'h0100);
        chk("rr3_a1", 64'(bus.mem_read_address[1]), 16'h0101);
        chk("rr3_ptr", 64'(u_dut.rr_ptr), 2);
        bus.mem_read_data[0] = 32'h1111_0000;
        bus.mem_read_data[1] = 32'h2222_0001;
        bus.mem_read_ready = 2'b11;
        tick();
        chk("rr3_d0", 64'(bus.consumer_read_data[0]), 32'h1111_0000);
        chk("rr3_d1", 64'(bus.consumer_read_data[1]), 32'h2222_0001);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b0000;
        tick();
        chk("rr3_idle", 64'({bus.consumer_read_ready, bus.mem_read_valid}), 0);

        // consumer 2 reads 0x0040
        bus.consumer_read_address[2] = 16'h0040;
        bus.consumer_read_valid = 4'b0100;
        tick();
        chk("c2_vld", 64'(bus.mem_read_valid), 2'b01);
        chk("c2_addr", 64'(bus.mem_read_address[0]), 16'h0040);
        bus.mem_read_data[0] = 32'hDEADBEEF;
        bus.mem_read_ready[0] = 1'b1;
        tick();
        chk("c2_rdy", 64'(bus.consumer_read_ready), 4'b0100);
        chk("c2_data", 64'(bus.consumer_read_data[2]), 32'hDEADBEEF);
        bus.mem_read_ready = 2'b00;
        bus.mem_read_data[0] = 32'h0;
        bus.consumer_read_valid = 4'b0000;
        tick();
        chk("c2_clr", 64'(bus.consumer_read_ready), 0);
        chk("c2_st", 64'(u_dut.st[0]), 0);
        chk("c2_hold", 64'(bus.consumer_read_data[2]), 32'hDEADBEEF);

        // consumer 1 read and write together: read first
        bus.consumer_write_address[1] = 16'h0010;
        bus.consumer_write_data[1] = 32'h12345678;
        bus.consumer_read_valid = 4'b0010;
        bus.consumer_write_valid = 4'b0010;
        tick();
        chk("rw_rv", 64'(bus.mem_read_valid), 2'b01);
        chk("rw_wv", 64'(bus.mem_write_valid), 0);
        chk("rw_ptr", 64'(u_dut.rr_ptr), 2);
        bus.mem_read_data[0] = 32'hAAAA5555;
        bus.mem_read_ready[0] = 1'b1;
        tick();
        chk("rw_rrdy", 64'(bus.consumer_read_ready), 4'b0010);
        chk("rw_wrdy0", 64'(bus.consumer_write_ready), 0);
        chk("rw_wv1", 64'(bus.mem_write_valid), 0);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b0000;
        tick();
        chk("rw_wv2", 64'(bus.mem_write_valid), 0);
        tick();
        chk("rw_wgnt", 64'(bus.mem_write_valid), 2'b01);
        chk("rw_waddr", 64'(bus.mem_write_address[0]), 16'h0010);
        chk("rw_wdata", 64'(bus.mem_write_data[0]), 32'h12345678);
        bus.mem_write_ready[0] = 1'b1;
        tick();
        chk("rw_wrdy", 64'(bus.consumer_write_ready), 4'b0010);
        chk("rw_wdrop", 64'(bus.mem_write_valid), 0);
        bus.mem_write_ready = 2'b00;
        bus.consumer_write_valid = 4'b0000;
        tick();
        chk("rw_wclr", 64'(bus.consumer_write_ready), 0);

        // memory never ready for consumer 0
        bus.consumer_read_valid = 4'b0001;
        tick();
        chk("to_gnt", 64'(bus.mem_read_valid), 2'b01);
`ifdef MEM_CTRL_TIMEOUT_EN
        tick(7);
        chk("to_early", 64'(bus.consumer_read_ready), 0);
        tick();
        chk("to_rdy", 64'(bus.consumer_read_ready), 4'b0001);
        chk("to_err", 64'(bus.consumer_error), 4'b0001);
        chk("to_mrv", 64'(bus.mem_read_valid), 0);
        chk("to_data", 64'(bus.consumer_read_data[0]), 0);
        bus.consumer_read_valid = 4'b0000;
        tick();
        chk("to_eclr", 64'(bus.consumer_error), 0);
`else
        tick(100);
        chk("nto_mrv", 64'(bus.mem_read_valid), 2'b01);
        chk("nto_rdy", 64'(bus.consumer_read_ready), 0);
        chk("nto_err", 64'(bus.consumer_error), 0);
        bus.mem_read_ready[0] = 1'b1;
        tick();
        chk("nto_done", 64'(bus.consumer_read_ready), 4'b0001);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b0000;
        tick();
`endif
        chk("to_idle", 64'(bus.consumer_read_ready), 0);

        // reset in the middle of a read
        bus.consumer_read_valid = 4'b1000;
        tick();
        chk("ra_gnt", 64'(bus.mem_read_valid), 2'b01);
        chk("ra_addr", 64'(bus.mem_read_address[0]), 16'h0103);
        #2 reset = 1'b1;
        #1;
        chk("ra_mrv", 64'(bus.mem_read_valid), 0);
        chk("ra_addr0", 64'(bus.mem_read_address[0]), 0);
        chk("ra_rd", 64'(bus.consumer_read_data[2]), 0);
        bus.consumer_read_valid = 4'b0000;
        bus.mem_read_ready = 2'b01;
        #2 reset = 1'b0;
        tick(3);
        chk("ra_stale", 64'(bus.consumer_read_ready), 0);
        chk("ra_mrv2", 64'(bus.mem_read_valid), 0);
        bus.mem_read_ready = 2'b00;
        bus.consumer_read_valid = 4'b0010;
        tick();
        chk("ra_first", 64'(bus.mem_read_valid), 2'b01);
        chk("ra_faddr", 64'(bus.mem_read_address[0]), 16'h0101);
        bus.consumer_read_valid = 4'b0000;

        // read-only build never issues writes
        bus_ro.consumer_write_address[0] = 16'h0020;
        bus_ro.consumer_write_data[0] = 32'hCAFEF00D;
        bus_ro.consumer_write_valid = 4'b0001;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("ro_mwv", 64'(bus_ro.mem_write_valid), 0);
            chk("ro_wrdy", 64'(bus_ro.consumer_write_ready), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
